// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store sequencer and its alignment checker.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; funct3[2] only selects zero-extension for loads.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check for an RV32I load/store: size alignment plus funct3 validity.
module lsu_align_check (
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  input  logic       is_store,
  output logic       legal
);
  import lsu_pkg::*;

  logic size_ok;

  always_comb begin
    size_ok = 1'b0;
    case (funct3[1:0])
      SIZE_BYTE: size_ok = 1'b1;
      SIZE_HALF: size_ok = ~addr_lsb[0];
      SIZE_WORD: size_ok = (addr_lsb == 2'b00);
      default:   size_ok = 1'b0;
    endcase
    // Stores have no unsigned forms; loads reject 110 since RV32I has no LWU.
    legal = size_ok
          & ~(is_store & funct3[2])
          & ~(~is_store & (funct3 == 3'b110));
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Sequences one data-memory access per handshake: checks alignment, holds the dmem
// request stable, waits out the read latency and returns a one-cycle done pulse.
module lsu_sequencer #(
  parameter int READ_LATENCY = 1,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] dmem_address,
  output logic [XLEN-1:0] dmem_data_in,
  output logic [2:0]      dmem_funct3,
  output logic            dmem_wren,
  input  logic [XLEN-1:0] dmem_data_out
);
  import lsu_pkg::*;

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  lsu_state_e       state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  store_data_q, store_data_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  load_data_q, load_data_d;
  logic             legal;

  lsu_align_check u_align_check (
    .funct3   (funct3),
    .addr_lsb (addr[1:0]),
    .is_store (is_store),
    .legal    (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = store_data;
          error_d      = ~legal;
          state_d      = legal ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_INIT;
        state_d = is_store_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          load_data_d = dmem_data_out;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The request registers feed memory directly, so the request stays stable until the next accept.
  assign dmem_address = addr_q;
  assign dmem_data_in = store_data_q;
  assign dmem_funct3  = funct3_q;
  assign dmem_wren    = (state_q == ACCESS) & is_store_q;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == DONE) & error_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: a request-level model predicts completions and
// memory writes, and negedge monitors compare them against what the DUT presents.
module tb_lsu_sequencer;

  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] load_data;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [2:0]  dmem_funct3;
  logic        dmem_wren;
  logic [31:0] dmem_data_out;

  lsu_sequencer #(.READ_LATENCY(RL), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .is_store      (is_store),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .load_data     (load_data),
    .dmem_address  (dmem_address),
    .dmem_data_in  (dmem_data_in),
    .dmem_funct3   (dmem_funct3),
    .dmem_wren     (dmem_wren),
    .dmem_data_out (dmem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input int idx);
    return (32'h9E37_79B9 * (idx + 1)) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: 64 words, only full-word stores update it; data is valid only
  // once the address has been held for RL edges, otherwise a poison value is returned.
  logic [31:0] wmem [64];
  bit   [63:0] wvalid = '0;
  logic [31:0] last_addr = '0;
  int          age = 0;
  logic [5:0]  rd_idx;
  logic [31:0] rd_word;

  assign rd_idx        = dmem_address[7:2];
  assign rd_word       = wvalid[rd_idx] ? wmem[rd_idx] : init_word(int'(rd_idx));
  assign dmem_data_out = (dmem_address == last_addr && age >= RL) ? rd_word : 32'hBADC_0FFE;

  always @(posedge clk) begin
    if (dmem_address != last_addr) age <= 1;
    else if (age < 16) age <= age + 1;
    last_addr <= dmem_address;
    if (dmem_wren === 1'b1 && dmem_funct3 == 3'b010) begin
      wmem[dmem_address[7:2]]   <= dmem_data_in;
      wvalid[dmem_address[7:2]] <= 1'b1;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  bit   [63:0] ref_valid = '0;
  logic [31:0] ref_ld = '0;

  typedef struct { logic err; logic [31:0] ld; int cyc; } done_t;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] f3; int cyc; } wr_t;
  done_t exp_done[$];
  wr_t   exp_wr[$];

  function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (f3[1:0] == 2'b11) return 1'b0;
    nbytes = 1 << f3[1:0];
    if ((int'(a[7:0]) % nbytes) != 0) return 1'b0;
    if (st && f3 >= 3'd4) return 1'b0;
    if (!st && f3 == 3'd6) return 1'b0;
    return 1'b1;
  endfunction

  // Called right after a negedge; returns at a negedge with start dropped.
  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input bit spam);
    int    waited = 0;
    bit    legal;
    done_t e;
    wr_t   w;
    while (busy !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checkOutput("busy_timeout", busy, 32'd0);
      return;
    end
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    legal = ref_legal(st, f3, a);
    e.err = !legal;
    e.cyc = cyc + (!legal ? 1 : (st ? 2 : 2 + RL));
    if (legal && !st) ref_ld = ref_valid[a[7:2]] ? ref_mem[a[7:2]] : init_word(int'(a[7:2]));
    e.ld = ref_ld;
    if (legal && st) begin
      w.a = a; w.d = d; w.f3 = f3; w.cyc = cyc + 1;
      exp_wr.push_back(w);
      if (f3 == 3'b010) begin
        ref_mem[a[7:2]]   = d;
        ref_valid[a[7:2]] = 1'b1;
      end
    end
    exp_done.push_back(e);
    @(negedge clk);
    checkOutput("busy_after_start", busy, 32'd1);
    if (spam) begin
      waited = 0;
      while (busy === 1'b1 && waited < 50) begin
        start = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        @(negedge clk);
        waited++;
      end
    end
    start = 1'b0;
  endtask

  // Completion and write monitors.
  always @(negedge clk) begin : monitor
    done_t e;
    wr_t   w;
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_done.size() == 0) checkOutput("unexpected_done", done, 32'd0);
        else begin
          e = exp_done.pop_front();
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("error", error, e.err);
          checkOutput("load_data", load_data, e.ld);
        end
      end else if (exp_done.size() > 0 && cyc > exp_done[0].cyc) begin
        e = exp_done.pop_front();
        checkOutput("missing_done", done, 32'd1);
      end
      if (dmem_wren === 1'b1) begin
        if (exp_wr.size() == 0) checkOutput("unexpected_write", dmem_wren, 32'd0);
        else begin
          w = exp_wr.pop_front();
          checkOutput("wr_cycle", cyc, w.cyc);
          checkOutput("wr_address", dmem_address, w.a);
          checkOutput("wr_data", dmem_data_in, w.d);
          checkOutput("wr_funct3", dmem_funct3, w.f3);
        end
      end else if (exp_wr.size() > 0 && cyc > exp_wr[0].cyc) begin
        w = exp_wr.pop_front();
        checkOutput("missing_write", dmem_wren, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int waited;
    for (int i = 0; i < 64; i++) begin
      wmem[i]    = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 32'd0);
    checkOutput("reset_done", done, 32'd0);
    checkOutput("reset_error", error, 32'd0);
    checkOutput("reset_wren", dmem_wren, 32'd0);
    checkOutput("reset_load_data", load_data, 32'd0);
    checkOutput("reset_dmem_address", dmem_address, 32'd0);
    checkOutput("reset_dmem_data_in", dmem_data_in, 32'd0);
    checkOutput("reset_dmem_funct3", dmem_funct3, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_1004, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h0000_1003, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h0000_1000, 32'h0, 1'b0);
    applyStimulus(1'b1, 3'b110, 32'h0000_1000, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_1008, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b100, 32'h0000_1005, 32'h0, 1'b0);

    // Abort a load in WAIT, then confirm a fresh store still completes normally.
    applyStimulus(1'b0, 3'b010, 32'h0000_1010, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_done.delete();
    ref_ld = '0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 32'd0);
    checkOutput("abort_done", done, 32'd0);
    checkOutput("abort_wren", dmem_wren, 32'd0);
    checkOutput("abort_load_data", load_data, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'h0000_1000 | ($urandom & 32'h0000_00FF);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      applyStimulus(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                    $urandom_range(0, 3) == 0);
    end

    waited = 0;
    while ((exp_done.size() > 0 || exp_wr.size() > 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pending_done", exp_done.size(), 32'd0);
    checkOutput("pending_writes", exp_wr.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
